// File: rtl/dsp_mac_sequencer_if.sv
// Stream bundle for dsp_mac_sequencer: operand input channel and result output channel.
// The sequencer is the slave; the operand source / result sink is the master.
interface dsp_mac_sequencer_if #(
  parameter int unsigned CNT_W = 16
) ();
  // operand channel
  logic                    in_valid;
  logic                    in_ready;
  logic signed [17:0]      in_a;
  logic signed [17:0]      in_b;
  logic                    in_last;
  // result channel
  logic                    out_valid;
  logic                    out_ready;
  logic        [47:0]      out_p;
  logic        [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_p, out_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_p, out_count
  );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Streaming multiply-accumulate controller for one DSP48A1 slice configured with
// A1REG=B1REG=MREG=PREG=OPMODEREG=1 and synchronous slice reset. Operands are
// registered onto dsp_a/dsp_b on acceptance; the matching OPMODE follows one edge
// later so that it meets the product in the M register. After the pipeline drains
// the accumulated P is captured and offered on the result channel.
module dsp_mac_sequencer #(
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  dsp_mac_sequencer_if.slave  io_bus,
  output logic                o_busy,
  output logic [17:0]         o_dsp_a,
  output logic [17:0]         o_dsp_b,
  output logic [7:0]          o_dsp_opmode,
  output logic                o_dsp_ce,
  output logic                o_dsp_rst,
  input  logic [47:0]         i_dsp_p
);

  // X=M, Z=0 starts a fresh sum; X=M, Z=P accumulates; all-zero clears P while idle.
  localparam logic [7:0] OpIdle  = 8'h00;
  localparam logic [7:0] OpFirst = 8'h01;
  localparam logic [7:0] OpAcc   = 8'h09;

  localparam int unsigned         DrainW    = $clog2(PIPE_LAT + 2);
  localparam logic [DrainW-1:0]   DrainLast = DrainW'(PIPE_LAT);
  localparam logic [CNT_W-1:0]    CntMax    = '1;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e              r_state;
  state_e              w_state_next;

  logic [17:0]         r_dsp_a;
  logic [17:0]         r_dsp_b;
  logic [7:0]          r_op_sched;
  logic [7:0]          r_dsp_opmode;
  logic                r_dsp_ce;
  logic                r_dsp_rst;
  logic [CNT_W-1:0]    r_count;
  logic [DrainW-1:0]   r_drain;
  logic [47:0]         r_out_p;
  logic [CNT_W-1:0]    r_out_count;

  logic                w_in_ready;
  logic                w_out_valid;
  logic [17:0]         w_a_next;
  logic [17:0]         w_b_next;
  logic [7:0]          w_op_next;
  logic [CNT_W-1:0]    w_count_next;
  logic [DrainW-1:0]   w_drain_next;
  logic                w_capture;

  // State register; reset parks the controller in INIT so the slice gets one clean reset cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StInit;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, handshake outputs and next values for the slice drive registers.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_a_next     = '0;
    w_b_next     = '0;
    w_op_next    = OpIdle;
    w_count_next = r_count;
    w_drain_next = r_drain;
    w_capture    = 1'b0;

    case (r_state)
      StInit: begin
        w_state_next = StIdle;
      end

      StIdle: begin
        w_in_ready = 1'b1;
        if (io_bus.in_valid) begin
          w_a_next     = io_bus.in_a;
          w_b_next     = io_bus.in_b;
          w_op_next    = OpFirst;
          w_count_next = CNT_W'(1);
          w_drain_next = '0;
          w_state_next = io_bus.in_last ? StDrain : StRun;
        end
      end

      StRun: begin
        w_in_ready = 1'b1;
        // Bubbles feed a zero product with ACC, so P simply holds.
        w_op_next  = OpAcc;
        if (io_bus.in_valid) begin
          w_a_next = io_bus.in_a;
          w_b_next = io_bus.in_b;
          if (r_count != CntMax) begin
            w_count_next = r_count + CNT_W'(1);
          end
          if (io_bus.in_last) begin
            w_drain_next = '0;
            w_state_next = StDrain;
          end
        end
      end

      StDrain: begin
        w_op_next = OpAcc;
        // r_drain counts edges since the last acceptance; P is final once PIPE_LAT have passed.
        if (r_drain == DrainLast) begin
          w_capture    = 1'b1;
          w_state_next = StDone;
        end else begin
          w_drain_next = r_drain + DrainW'(1);
        end
      end

      StDone: begin
        w_out_valid = 1'b1;
        if (io_bus.out_ready) begin
          w_state_next = StIdle;
        end
      end

      default: begin
        w_state_next = StInit;
      end
    endcase
  end

  // Slice drive, beat counter and result capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dsp_a      <= '0;
      r_dsp_b      <= '0;
      r_op_sched   <= OpIdle;
      r_dsp_opmode <= OpIdle;
      r_dsp_ce     <= 1'b0;
      r_dsp_rst    <= 1'b1;
      r_count      <= '0;
      r_drain      <= '0;
      r_out_p      <= '0;
      r_out_count  <= '0;
    end else begin
      r_dsp_a      <= w_a_next;
      r_dsp_b      <= w_b_next;
      // OPMODE trails its operands by one edge to line up with the M register.
      r_op_sched   <= w_op_next;
      r_dsp_opmode <= r_op_sched;
      r_dsp_ce     <= 1'b1;
      r_dsp_rst    <= 1'b0;
      r_count      <= w_count_next;
      r_drain      <= w_drain_next;
      if (w_capture) begin
        r_out_p     <= i_dsp_p;
        r_out_count <= r_count;
      end
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = w_out_valid;
  assign io_bus.out_p     = r_out_p;
  assign io_bus.out_count = r_out_count;

  assign o_busy       = (r_state != StIdle);
  assign o_dsp_a      = r_dsp_a;
  assign o_dsp_b      = r_dsp_b;
  assign o_dsp_opmode = r_dsp_opmode;
  assign o_dsp_ce     = r_dsp_ce;
  assign o_dsp_rst    = r_dsp_rst;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP48A1 slice (A1/B1, M, OPMODE, P registers).
module tb_dsp_mac_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dsp_mac_sequencer_if #(.CNT_W(16)) bus ();

  logic        busy;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic [7:0]  dsp_opmode;
  logic        dsp_ce;
  logic        dsp_rst;
  logic [47:0] dsp_p;

  dsp_mac_sequencer #(
    .PIPE_LAT(3),
    .CNT_W   (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .io_bus      (bus.slave),
    .o_busy      (busy),
    .o_dsp_a     (dsp_a),
    .o_dsp_b     (dsp_b),
    .o_dsp_opmode(dsp_opmode),
    .o_dsp_ce    (dsp_ce),
    .o_dsp_rst   (dsp_rst),
    .i_dsp_p     (dsp_p)
  );

  // Slice model: sync reset, D/C/PCIN/carry tied to zero.
  logic signed [17:0] s_a1, s_b1;
  logic signed [35:0] s_m;
  logic        [7:0]  s_opm;
  logic        [47:0] s_p;
  always @(posedge clk) begin
    if (dsp_rst) begin
      s_a1 <= '0; s_b1 <= '0; s_m <= '0; s_opm <= '0; s_p <= '0;
    end else if (dsp_ce) begin
      s_a1  <= dsp_a;
      s_b1  <= dsp_b;
      s_m   <= s_a1 * s_b1;
      s_opm <= dsp_opmode;
      s_p   <= ((s_opm[3:2] == 2'b10) ? s_p : 48'd0) +
               ((s_opm[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'd0);
    end
  end
  assign dsp_p = s_p;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Captures OPMODE during the cycle after the first beat of a vector is accepted.
  int         issue_edge = -10;
  logic [7:0] issue_op;
  always @(negedge clk) if (cyc == issue_edge + 1) issue_op = dsp_opmode;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [17:0] a, input logic [17:0] b, input logic last,
                           output int e);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    while (!bus.in_ready && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) check("accept_timeout", 64'd0, 64'd1);
    step();
    e = cyc;
  endtask

  task automatic wait_valid(input string name, output int e);
    int guard = 0;
    while (!bus.out_valid && guard < 40) begin
      step();
      guard++;
    end
    if (!bus.out_valid) check({name, "_valid_timeout"}, 64'd0, 64'd1);
    e = cyc;
  endtask

  task automatic handshake(input string name);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({name, "_valid_cleared"}, 64'(bus.out_valid), 64'd0);
    check({name, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_p"},     64'(bus.out_p),     64'd0);
    check({tag, "_out_count"}, 64'(bus.out_count), 64'd0);
    check({tag, "_busy"},      64'(busy),          64'd1);
    check({tag, "_dsp_a"},     64'(dsp_a),         64'd0);
    check({tag, "_dsp_b"},     64'(dsp_b),         64'd0);
    check({tag, "_opmode"},    64'(dsp_opmode),    64'd0);
    check({tag, "_dsp_ce"},    64'(dsp_ce),        64'd0);
    check({tag, "_dsp_rst"},   64'(dsp_rst),       64'd1);
  endtask

  typedef struct {
    string             name;
    int                n;
    int                gap;    // idle cycles inserted between beat 0 and beat 1
    logic [3:0][17:0]  a;
    logic [3:0][17:0]  b;
    logic [47:0]       exp_p;
    int                exp_cnt;
    int                exp_lat; // edges from first acceptance to out_valid
  } vec_t;

  function automatic vec_t mk(input string name, input int n, input int gap,
                              input int a0, input int b0, input int a1, input int b1,
                              input int a2, input int b2, input int a3, input int b3,
                              input logic [47:0] p, input int cnt, input int lat);
    vec_t v;
    v.name = name; v.n = n; v.gap = gap;
    v.a[0] = 18'(a0); v.b[0] = 18'(b0);
    v.a[1] = 18'(a1); v.b[1] = 18'(b1);
    v.a[2] = 18'(a2); v.b[2] = 18'(b2);
    v.a[3] = 18'(a3); v.b[3] = 18'(b3);
    v.exp_p = p; v.exp_cnt = cnt; v.exp_lat = lat;
    return v;
  endfunction

  task automatic run_vector(input vec_t v);
    int e, e_first, e_last, e_valid;
    e_first = 0;
    e_last  = 0;
    issue_op = 8'hff;
    for (int i = 0; i < v.n; i++) begin
      if (i == 1 && v.gap > 0) begin
        bus.in_valid = 1'b0;
        repeat (v.gap) step();
      end
      send_beat(v.a[i], v.b[i], i == v.n - 1, e);
      if (i == 0) begin
        e_first    = e;
        issue_edge = e;
      end
      e_last = e;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    wait_valid(v.name, e_valid);
    check({v.name, "_out_p"},      64'(bus.out_p),     64'(v.exp_p));
    check({v.name, "_out_count"},  64'(bus.out_count), 64'(v.exp_cnt));
    check({v.name, "_lat_first"},  64'(e_valid - e_first), 64'(v.exp_lat));
    check({v.name, "_lat_last"},   64'(e_valid - e_last),  64'd4);
    check({v.name, "_first_opmode"}, 64'(issue_op),    64'h01);
    handshake(v.name);
  endtask

  vec_t vecs[5];

  initial begin
    int e, e_valid, seen;

    vecs[0] = mk("b2b",     3, 0,  2, 3,  4, 5, -1, 7, 0, 0, 48'h13, 3, 6);
    vecs[1] = mk("gapped",  3, 2,  2, 3,  4, 5, -1, 7, 0, 0, 48'h13, 3, 8);
    vecs[2] = mk("min_one", 1, 0, -131072, -131072, 0, 0, 0, 0, 0, 0,
                 48'h0004_0000_0000, 1, 4);
    vecs[3] = mk("neg_mix", 2, 0, -3, 5,  2, -4, 0, 0, 0, 0, 48'hffff_ffff_ffe9, 2, 5);
    vecs[4] = mk("extreme", 4, 0, 131071, 131071, 131071, 131071, -131072, 131071, 1, -1,
                 48'h0003_fffa_0001, 4, 7);

    // Reset held for three cycles with random inputs.
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_a      = 18'($urandom);
      bus.in_b      = 18'($urandom);
      bus.in_last   = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
      check_reset_outputs("rst_hold");
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    #1;
    check("init_dsp_rst",  64'(dsp_rst),     64'd1);
    check("init_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    check("post_init_dsp_rst",  64'(dsp_rst),      64'd0);
    check("post_init_dsp_ce",   64'(dsp_ce),       64'd1);
    check("post_init_in_ready", 64'(bus.in_ready), 64'd1);
    check("post_init_busy",     64'(busy),         64'd0);

    for (int i = 0; i < 5; i++) run_vector(vecs[i]);

    // Backpressure: result held in DONE while a beat is presented.
    send_beat(18'd2, 18'd3, 1'b1, e);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    wait_valid("bp", e_valid);
    check("bp_out_p", 64'(bus.out_p), 64'd6);
    bus.in_valid = 1'b1;
    bus.in_a     = 18'd7;
    bus.in_b     = 18'd7;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_p",     64'(bus.out_p),     64'd6);
      check("bp_hold_ready", 64'(bus.in_ready),  64'd0);
      check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    handshake("bp");
    run_vector(mk("after_bp", 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 48'h1, 1, 4));

    // Reset in the middle of a four-beat vector.
    send_beat(18'd5, 18'd5, 1'b0, e);
    send_beat(18'd6, 18'd6, 1'b0, e);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    step();
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.out_valid) seen++;
    end
    check("mid_rst_no_result", 64'(seen), 64'd0);
    run_vector(mk("after_rst", 1, 0, 3, 3, 0, 0, 0, 0, 0, 0, 48'h9, 1, 4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
